// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely by clk: pins pass through synchronisers, sclk edges
// are detected and registered, and the frame/shift logic acts one cycle later.
module spi_slave_sync #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SS_ACT      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ss,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic          CPOL_L   = CPOL[0];
    localparam logic          CPHA_L   = CPHA[0];
    localparam logic          MSB_L    = MSB_FIRST[0];
    localparam logic          SS_L     = SS_ACT[0];

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   mosi_smp_q, mosi_smp_d;
    logic                   sample_ev_q, sample_ev_d;
    logic                   shift_ev_q, shift_ev_d;

    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   word_done_q, word_done_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   miso_q, miso_d;

    logic sclk_s, sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic frame_on, load_pt, tx_upd, word_end, handshake;

    // Synchronisers and registered edge events; mosi is captured alongside the event.
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        lead_edge   = CPOL_L ? sclk_fall : sclk_rise;
        trail_edge  = CPOL_L ? sclk_rise : sclk_fall;
        sample_ev_d = CPHA_L ? trail_edge : lead_edge;
        shift_ev_d  = CPHA_L ? lead_edge : trail_edge;
        ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        mosi_smp_d  = mosi_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        word_done_d   = word_done_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        miso_d        = miso_q;
        load_pt       = 1'b0;
        tx_upd        = 1'b0;
        word_end      = 1'b0;
        frame_on      = (ss_prev_q == SS_L);
        handshake     = rx_valid_q && rx_ready;

        if (state_q == S_IDLE) begin
            if (frame_on) begin
                state_d = S_ACTIVE;
                load_pt = !CPHA_L;
            end
        end else if (!frame_on) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            tx_shift_d  = '0;
            word_done_d = 1'b0;
            miso_d      = 1'b0;
        end else begin
            if (sample_ev_q) begin
                rx_shift_d = MSB_L ? {rx_shift_q[WIDTH-2:0], mosi_smp_q}
                                   : {mosi_smp_q, rx_shift_q[WIDTH-1:1]};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d   = '0;
                    word_done_d = 1'b1;
                    word_end    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (shift_ev_q) begin
                word_done_d = 1'b0;
                if (bit_cnt_q == '0 && (CPHA_L || word_done_q)) begin
                    load_pt = 1'b1;
                end else begin
                    tx_shift_d = MSB_L ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, tx_shift_q[WIDTH-1:1]};
                    tx_upd     = 1'b1;
                end
            end
        end

        // An empty holding register at a load point sends zeros.
        if (load_pt) begin
            tx_upd = 1'b1;
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end
        if (tx_upd) begin
            miso_d = MSB_L ? tx_shift_d[WIDTH-1] : tx_shift_d[0];
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (word_end) begin
            if (!rx_valid_q || handshake) begin
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (handshake) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync_q     <= {SYNC_STAGES{~SS_L}};
            sclk_sync_q   <= {SYNC_STAGES{CPOL_L}};
            mosi_sync_q   <= '0;
            ss_prev_q     <= ~SS_L;
            sclk_prev_q   <= CPOL_L;
            mosi_smp_q    <= 1'b0;
            sample_ev_q   <= 1'b0;
            shift_ev_q    <= 1'b0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            word_done_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            ss_sync_q     <= ss_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            ss_prev_q     <= ss_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            mosi_smp_q    <= mosi_smp_d;
            sample_ev_q   <= sample_ev_d;
            shift_ev_q    <= shift_ev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            word_done_q   <= word_done_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
        end
    end

    assign busy        = (state_q == S_ACTIVE);
    assign miso_oe     = busy;
    assign miso        = miso_q;
    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: one instance per SPI mode, a bit-level master drives the
// selected one while a negedge monitor checks rx words, flag pulses and miso timing.
module tb_spi_slave_sync;
    localparam int H   = 6;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] cur;
    logic       ss_drv, sclk_drv, mosi_drv, tx_valid_drv, rx_ready_drv;
    logic [7:0] tx_data;

    logic [3:0]      ss_v, sclk_v, tx_valid_v, rx_ready_v;
    logic [3:0]      miso_v, miso_oe_v, tx_ready_v, rx_valid_v, rx_overrun_v, tx_underrun_v, busy_v;
    logic [3:0][7:0] rx_data_v;

    int cyc = 0;
    int last_ev = 0;
    int n_tests = 0;
    int n_fail = 0;
    int und_cnt = 0, ovr_cnt = 0, exp_und = 0, exp_ovr = 0;
    bit model_pend = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic miso_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ss_v[i]       = (cur == i) ? ss_drv : 1'b1;
            sclk_v[i]     = (cur == i) ? sclk_drv : ((i / 2) != 0);
            tx_valid_v[i] = (cur == i) && tx_valid_drv;
            rx_ready_v[i] = (cur == i) ? rx_ready_drv : 1'b1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .WIDTH(8), .CPOL(g / 2), .CPHA(g % 2),
            .MSB_FIRST(1), .SS_ACT(0), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ss(ss_v[g]), .sclk(sclk_v[g]), .mosi(mosi_drv),
            .miso(miso_v[g]), .miso_oe(miso_oe_v[g]),
            .tx_data(tx_data), .tx_valid(tx_valid_v[g]), .tx_ready(tx_ready_v[g]),
            .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]), .rx_ready(rx_ready_v[g]),
            .rx_overrun(rx_overrun_v[g]), .tx_underrun(tx_underrun_v[g]), .busy(busy_v[g])
        );
    end

    logic miso_c, miso_oe_c, tx_ready_c, rx_valid_c, rx_ready_c, busy_c;
    logic [7:0] rx_data_c;
    assign miso_c     = miso_v[cur];
    assign miso_oe_c  = miso_oe_v[cur];
    assign tx_ready_c = tx_ready_v[cur];
    assign rx_valid_c = rx_valid_v[cur];
    assign rx_ready_c = rx_ready_v[cur];
    assign busy_c     = busy_v[cur];
    assign rx_data_c  = rx_data_v[cur];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (mode %0d, t=%0t)", name, act, exp, cur, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: rx scoreboard on handshakes, flag pulse counts, miso change timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_c && rx_ready_c) begin
                if (exp_rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h with no word expected", rx_data_c);
                end else begin
                    chk("rx_data", rx_data_c, exp_rx_q.pop_front());
                end
            end
            if (tx_underrun_v[cur]) und_cnt++;
            if (rx_overrun_v[cur]) ovr_cnt++;
            if (miso_c !== miso_last) chk("miso_change_latency", cyc - last_ev, LAT);
        end
        miso_last = miso_c;
    end

    task automatic check_reset(input int m);
        chk("rst_miso", miso_v[m], 0);
        chk("rst_miso_oe", miso_oe_v[m], 0);
        chk("rst_tx_ready", tx_ready_v[m], 1);
        chk("rst_rx_valid", rx_valid_v[m], 0);
        chk("rst_rx_data", rx_data_v[m], 0);
        chk("rst_rx_overrun", rx_overrun_v[m], 0);
        chk("rst_tx_underrun", tx_underrun_v[m], 0);
        chk("rst_busy", busy_v[m], 0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        cur      = m;
        sclk_drv = m[1];
        ss_drv   = 1'b1;
        tick(H);
    endtask

    task automatic preload(input logic [7:0] w);
        chk("tx_ready_before_load", tx_ready_c, 1);
        tx_data      = w;
        tx_valid_drv = 1'b1;
        tick(1);
        tx_valid_drv = 1'b0;
        chk("tx_ready_after_load", tx_ready_c, 0);
        exp_tx_q.push_back(w);
    endtask

    task automatic load_model(output logic [7:0] w);
        if (exp_tx_q.size() > 0) begin
            w = exp_tx_q.pop_front();
        end else begin
            w = 8'h00;
            exp_und++;
        end
    endtask

    task automatic rx_model(input logic [7:0] w);
        if (rx_ready_drv) begin
            exp_rx_q.push_back(w);
        end else if (!model_pend) begin
            exp_rx_q.push_back(w);
            model_pend = 1'b1;
        end else begin
            exp_ovr++;
        end
    endtask

    // Master: nbits over up to two words; CPHA=0 frames release ss before the last trailing edge.
    task automatic spi_frame(input int nbits, input logic [7:0] w0, input logic [7:0] w1, input bit do_reset);
        logic [7:0] wv[2];
        logic [7:0] ev[2];
        logic [7:0] got[2];
        int wi, bi;
        wv[0] = w0; wv[1] = w1;
        ev[0] = 8'h00; ev[1] = 8'h00;
        got[0] = 8'h00; got[1] = 8'h00;
        ss_drv   = 1'b0;
        mosi_drv = w0[7];
        last_ev  = cyc;
        if (!cur[0]) load_model(ev[0]);
        tick(H);
        chk("busy_active", busy_c, 1);
        chk("miso_oe_active", miso_oe_c, 1);
        for (int k = 0; k < nbits; k++) begin
            wi = k / 8;
            bi = 7 - (k % 8);
            if (!cur[0]) begin
                got[wi][bi] = miso_c;
                sclk_drv = ~cur[1];
                if (k % 8 == 7) rx_model(wv[wi]);
                tick(H);
                if (k != nbits - 1) begin
                    sclk_drv = cur[1];
                    last_ev  = cyc;
                    if (k % 8 == 7) load_model(ev[wi + 1]);
                    mosi_drv = wv[(k + 1) / 8][7 - ((k + 1) % 8)];
                    tick(H);
                end
            end else begin
                sclk_drv = ~cur[1];
                mosi_drv = wv[wi][bi];
                last_ev  = cyc;
                if (k % 8 == 0) load_model(ev[wi]);
                tick(H);
                got[wi][bi] = miso_c;
                sclk_drv = cur[1];
                if (k % 8 == 7) rx_model(wv[wi]);
                tick(H);
            end
        end
        if (do_reset) begin
            rst_n = 1'b0;
            tick(1);
            check_reset(cur);
            ss_drv   = 1'b1;
            sclk_drv = cur[1];
            mosi_drv = 1'b0;
            tick(H);
            rst_n = 1'b1;
            exp_tx_q.delete();
            model_pend = 1'b0;
            tick(H);
        end else begin
            ss_drv  = 1'b1;
            last_ev = cyc;
            tick(H);
            sclk_drv = cur[1];
            mosi_drv = 1'b0;
            tick(H);
            chk("busy_idle", busy_c, 0);
            chk("miso_oe_idle", miso_oe_c, 0);
            chk("miso_idle", miso_c, 0);
            for (int w = 0; w < nbits / 8; w++) chk("miso_word", got[w], ev[w]);
        end
        tick(H);
        chk("underrun_cnt", und_cnt, exp_und);
        chk("overrun_cnt", ovr_cnt, exp_ovr);
    endtask

    initial begin
        rst_n = 1'b0; cur = 2'd0;
        ss_drv = 1'b1; sclk_drv = 1'b0; mosi_drv = 1'b0;
        tx_valid_drv = 1'b0; tx_data = 8'h00; rx_ready_drv = 1'b1;
        tick(4);
        for (int m = 0; m < 4; m++) check_reset(m);
        rst_n = 1'b1;
        tick(H);

        for (int m = 0; m < 4; m++) begin
            set_mode(2'(m));
            preload(8'hA5);
            spi_frame(8, 8'h3C, 8'h00, 1'b0);
        end

        for (int m = 0; m < 2; m++) begin
            set_mode(2'(m));
            preload(8'h5A);
            spi_frame(16, 8'h11, 8'h22, 1'b0);
        end

        set_mode(2'd0);
        preload(8'hE7);
        rx_ready_drv = 1'b0;
        spi_frame(16, 8'hC3, 8'h7E, 1'b0);
        chk("rx_valid_held", rx_valid_c, 1);
        chk("rx_data_held", rx_data_c, 8'hC3);
        rx_ready_drv = 1'b1;
        model_pend   = 1'b0;
        tick(H);
        chk("rx_valid_cleared", rx_valid_c, 0);

        spi_frame(5, 8'hFF, 8'h00, 1'b0);
        preload(8'h42);
        spi_frame(8, 8'h81, 8'h00, 1'b0);

        set_mode(2'd1);
        preload(8'h24);
        spi_frame(0, 8'h00, 8'h00, 1'b0);
        chk("hold_kept", tx_ready_c, 0);
        spi_frame(8, 8'h5C, 8'h00, 1'b0);

        set_mode(2'd0);
        preload(8'h11);
        spi_frame(4, 8'hF0, 8'h00, 1'b1);
        preload(8'h66);
        spi_frame(8, 8'h9C, 8'h00, 1'b0);

        tick(20);
        chk("rx_queue_empty", exp_rx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (2..32).
REQ-002 SHALL have parameter CPOL, default 0, idle level of sclk.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = MSB first, 0 = LSB first, on both mosi and miso.
REQ-005 SHALL have parameter SS_ACT, default 0, ss level that selects the slave.
REQ-006 SHALL have parameter SYNC_STAGES, default 2, flip-flops per input synchroniser (2..3).
REQ-007 SHALL have port clk, input, 1 bit, sole system clock; all state changes on rising clk.
REQ-008 SHALL have port rst_n, input, 1 bit, reset; synchronous, active-low.
REQ-009 SHALL have ports ss, sclk and mosi, input, 1 bit each, asynchronous SPI pins.
REQ-010 SHALL have port miso, output, 1 bit, serial data out.
REQ-011 SHALL have port miso_oe, output, 1 bit, tri-state enable for miso.
REQ-012 SHALL have ports tx_data (input, WIDTH bits, next word to send), tx_valid (input, 1 bit) and tx_ready (output, 1 bit, holding register empty).
REQ-013 SHALL have ports rx_data (output, WIDTH bits, received word), rx_valid (output, 1 bit) and rx_ready (input, 1 bit, consumer accepts).
REQ-014 SHALL have ports rx_overrun, tx_underrun and busy, output, 1 bit each.

Function
REQ-015 SHALL pass ss, sclk and mosi through SYNC_STAGES-flop synchronisers; edges SHALL be detected by comparing the synchronised value with a one-cycle-delayed copy.
REQ-016 Leading edge SHALL be the rising sclk edge when CPOL=0 and the falling edge when CPOL=1; trailing edge SHALL be the opposite edge.
REQ-017 Sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; shift edge SHALL be the other edge.
REQ-018 Frame state SHALL be IDLE (ss inactive) or ACTIVE (ss == SS_ACT); busy SHALL be 1 exactly in ACTIVE.
REQ-019 sclk edges SHALL be ignored in IDLE.
REQ-020 On each sample edge in ACTIVE, synchronised mosi SHALL shift into the rx shift register and bit_cnt SHALL increment.
REQ-021 When bit_cnt reaches WIDTH it SHALL wrap to 0, and the word SHALL go to the rx path; ss held active SHALL start the next word without a gap.
REQ-022 The tx holding register SHALL load tx_data on clk when tx_valid && tx_ready; tx_ready SHALL be 1 when the register is empty.
REQ-023 Load point: CPHA=0: IDLE->ACTIVE transition, plus each shift edge with bit_cnt==0 that follows a word completion. CPHA=1: each shift edge with bit_cnt==0.
REQ-024 At a load point the holding word SHALL move to the tx shift register and tx_ready SHALL go to 1 on the next cycle.
REQ-025 If the holding register is empty at a load point, the shift register SHALL load all zeros and tx_underrun SHALL pulse high for 1 cycle.
REQ-026 miso SHALL present the current tx bit, selected per MSB_FIRST, and SHALL update only at load points and shift edges.
REQ-027 miso and miso_oe SHALL be 0 in IDLE; miso_oe SHALL be 1 in ACTIVE.
REQ-028 On word completion with rx_valid==0, rx_data SHALL take the word and rx_valid SHALL be 1 on the next cycle.
REQ-029 rx_valid SHALL stay high until a cycle where rx_valid && rx_ready, and SHALL clear on the cycle after it.
REQ-030 On word completion with rx_valid==1 and no handshake in the same cycle, the new word SHALL be dropped, rx_data SHALL be kept, and rx_overrun SHALL pulse 1 cycle.
REQ-031 On word completion in the same cycle as a handshake, the new word SHALL be accepted and there SHALL be no overrun.
REQ-032 Latency: an sclk or ss pin edge SHALL produce its effect (miso change, or rx_valid rise) SYNC_STAGES+2 clk cycles later.
REQ-033 On ss deassertion mid-word, partial rx bits SHALL be discarded with no rx_valid, the tx shift word SHALL be lost, bit_cnt SHALL clear, and the holding register SHALL be kept.
REQ-034 Correct operation SHALL require sclk high and low phases each of at least SYNC_STAGES+2 clk periods.

Reset
REQ-035 While rst_n==0 at a rising clk: synchronisers SHALL load inactive levels (sclk=CPOL, ss=!SS_ACT); state SHALL be IDLE; bit_cnt and both shift registers SHALL be 0; the holding register SHALL be empty.
REQ-036 Reset values: miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, tx_underrun=0, busy=0.
REQ-037 Reset asserted mid-frame SHALL abort the frame, and no rx_valid SHALL result from it.

Verification
REQ-038 Mode 0, WIDTH=8: preload 0xA5, master sends 0x3C -> miso carries 10100101, rx_data=0x3C, rx_valid high, no flags.
REQ-039 Modes 1/2/3: same transfer -> identical data; miso only changes on the mode's shift edge.
REQ-040 Two back-to-back words, ss held, only one tx word preloaded -> second miso word 0x00, tx_underrun pulses once.
REQ-041 rx_ready=0 across two words -> rx_data holds the first word, rx_overrun pulses once.
REQ-042 ss dropped after 5 bits, then a full frame 0x81 -> single rx_valid with 0x81.
REQ-043 rst_n low mid-word -> all outputs at reset values on the next clk; a subsequent frame is correct.
